// File: rtl/mioc_gate_pkg.sv
// Shared definitions for the MIOC single-gate pattern sequencer:
// function-select codes, FSM state encoding and the expected-output model.
package mioc_gate_pkg;

  localparam int unsigned MAX_IN = 8;

  typedef enum logic [2:0] {
    FUNC_NAND = 3'd0,
    FUNC_NOR  = 3'd1,
    FUNC_AND  = 3'd2,
    FUNC_OR   = 3'd3,
    FUNC_XOR  = 3'd4,
    FUNC_XNOR = 3'd5,
    FUNC_INV  = 3'd6,
    FUNC_RSVD = 3'd7
  } func_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_LOG,
    ST_DONE
  } state_e;

  // Bits of pat above n_in are masked off; the unused code 7 falls back to NAND.
  function automatic logic expected_z(input logic [MAX_IN-1:0] pat,
                                      input int unsigned       n_in,
                                      input logic [2:0]        func);
    logic [MAX_IN-1:0] mask;
    logic [MAX_IN-1:0] p;
    mask = {MAX_IN{1'b1}} >> (MAX_IN - n_in);
    p    = pat & mask;
    case (func)
      FUNC_NOR:  return ~|p;
      FUNC_AND:  return &(p | ~mask);
      FUNC_OR:   return |p;
      FUNC_XOR:  return ^p;
      FUNC_XNOR: return ~^p;
      FUNC_INV:  return ~pat[0];
      default:   return ~&(p | ~mask);
    endcase
  endfunction

endpackage

// File: rtl/mioc_sync.sv
// Multi-stage single-bit synchroniser for the asynchronous GUT output.
module mioc_sync
  import mioc_gate_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/mioc_gate_pattern_seq.sv
// Exhaustive input-pattern sequencer for single-gate characterisation:
// drives every input combination, samples the synchronised gate output and logs it.
module mioc_gate_pattern_seq
  import mioc_gate_pkg::*;
#(
  parameter int unsigned N_IN        = 2,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      func_sel,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_z,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            log_valid,
  input  logic            log_ready,
  output logic [N_IN-1:0] log_pattern,
  output logic            log_z,
  output logic            log_exp
);

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  if (N_IN < 1 || N_IN > MAX_IN) begin : g_bad_n_in
    $error("mioc_gate_pattern_seq: N_IN must be 1..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("mioc_gate_pattern_seq: SYNC_STAGES must be >= 2");
  end
  if (SETTLE_CYC < SYNC_STAGES + 1) begin : g_bad_settle
    $error("mioc_gate_pattern_seq: SETTLE_CYC must be >= SYNC_STAGES+1");
  end

  state_e          state;
  logic [N_IN-1:0] pattern;
  logic [2:0]      func_q;
  logic [CW-1:0]   settle_cnt;
  logic            z_sync;
  logic            exp_z;

  mioc_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gate_z),
    .q   (z_sync)
  );

  always_comb exp_z = expected_z(MAX_IN'(pattern), N_IN, func_q);

  // done/pass/busy are registered on entry to DONE so the pulse lines up with
  // the final LOG handshake; the DONE cycle itself only retires the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pattern     <= '0;
      func_q      <= '0;
      settle_cnt  <= '0;
      gate_in     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      log_valid   <= 1'b0;
      log_pattern <= '0;
      log_z       <= 1'b0;
      log_exp     <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      state     <= ST_IDLE;
      gate_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      log_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            func_q    <= func_sel;
            err_count <= '0;
            pattern   <= '0;
            busy      <= 1'b1;
            state     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          gate_in    <= pattern;
          settle_cnt <= CW'(SETTLE_CYC - 1);
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) state <= ST_SAMPLE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          log_pattern <= pattern;
          log_z       <= z_sync;
          log_exp     <= exp_z;
          log_valid   <= 1'b1;
          if (z_sync != exp_z) err_count <= err_count + 1'b1;
          state <= ST_LOG;
        end
        ST_LOG: begin
          if (log_ready) begin
            log_valid <= 1'b0;
            if (&pattern) begin
              done  <= 1'b1;
              pass  <= (err_count == '0);
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              pattern <= pattern + 1'b1;
              state   <= ST_APPLY;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mioc_gate_pattern_seq.sv
// Scoreboard bench for mioc_gate_pattern_seq: an N_IN=2 and an N_IN=3 instance.
module tb_mioc_gate_pattern_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // N_IN=2 instance
  logic       start2 = 0, abort2 = 0, ready2 = 1;
  logic [2:0] func2 = 3'd0;
  logic [1:0] gi2, lp2;
  logic       gz2, busy2, done2, pass2, lv2, lz2, le2;
  logic [2:0] err2;
  logic       stuck1 = 0;
  assign gz2 = stuck1 ? 1'b1 : ~&gi2;

  // N_IN=3 instance, output stuck at 0
  logic       start3 = 0, abort3 = 0, ready3 = 1;
  logic [2:0] func3 = 3'd0;
  logic [2:0] gi3, lp3;
  logic       gz3, busy3, done3, pass3, lv3, lz3, le3;
  logic [3:0] err3;
  assign gz3 = 1'b0;

  mioc_gate_pattern_seq #(.N_IN(2), .SETTLE_CYC(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .func_sel(func2),
    .gate_in(gi2), .gate_z(gz2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .log_valid(lv2), .log_ready(ready2), .log_pattern(lp2),
    .log_z(lz2), .log_exp(le2));

  mioc_gate_pattern_seq #(.N_IN(3), .SETTLE_CYC(4), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .func_sel(func3),
    .gate_in(gi3), .gate_z(gz3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .log_valid(lv3), .log_ready(ready3), .log_pattern(lp3),
    .log_z(lz3), .log_exp(le3));

  logic [3:0] q2[$];  // {pattern, z, exp}
  logic [4:0] q3[$];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Monitors: one comparison per record, on the cycle it first appears.
  bit seen2 = 0, seen3 = 0;
  initial forever begin
    @(negedge clk);
    if (rst || !lv2) seen2 = 0;
    else if (!seen2) begin
      seen2 = 1;
      if (q2.size() == 0) bound_fail("rec2_unexpected");
      else chk("rec2", {lp2, lz2, le2}, q2.pop_front());
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst || !lv3) seen3 = 0;
    else if (!seen3) begin
      seen3 = 1;
      if (q3.size() == 0) bound_fail("rec3_unexpected");
      else chk("rec3", {lp3, lz3, le3}, q3.pop_front());
    end
  end

  task automatic push_nand_ok();
    q2.push_back({2'b00, 1'b1, 1'b1});
    q2.push_back({2'b01, 1'b1, 1'b1});
    q2.push_back({2'b10, 1'b1, 1'b1});
    q2.push_back({2'b11, 1'b0, 1'b0});
  endtask

  task automatic start_run2(input logic [2:0] f, output int t0);
    @(negedge clk);
    func2 = f; start2 = 1;
    @(negedge clk);
    start2 = 0; t0 = cyc;
  endtask

  task automatic wait_done2(input string name, input int t0, input int lat,
                            input int exp_pass, input int exp_err);
    bit seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done2) seen = 1;
    end
    if (!seen) bound_fail({name, "_done"});
    else begin
      chk({name, "_latency"}, cyc - t0, lat);
      chk({name, "_pass"}, pass2, exp_pass);
      chk({name, "_err"}, err2, exp_err);
    end
  endtask

  task automatic wait_gi2(input logic [1:0] v, input string name);
    bit hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (gi2 == v && busy2) hit = 1;
    end
    if (!hit) bound_fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, bad, dones;
    bit hit;

    // Reset state
    @(negedge clk);
    chk("reset2", {gi2, busy2, done2, pass2, err2, lv2, lp2, lz2, le2}, 0);
    chk("reset3", {gi3, busy3, done3, pass3, err3, lv3, lp3, lz3, le3}, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    // 1: NAND, ideal gate; func_sel changes mid-run must be ignored
    push_nand_ok();
    start_run2(3'd0, t0);
    func2 = 3'd4;
    wait_done2("t1", t0, 28, 1, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", done2, 0);

    // 3: backpressure on pattern 01 for 10 cycles
    push_nand_ok();
    start_run2(3'd0, t0);
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (lv2 && lp2 == 2'b01) hit = 1;
    end
    if (!hit) bound_fail("t3_find_01");
    ready2 = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(lv2 && lp2 == 2'b01 && lz2 && le2 && gi2 == 2'b01)) bad++;
    end
    ready2 = 1;
    chk("t3_stall_stable", bad, 0);
    wait_done2("t3", t0, 38, 1, 0);

    // 2: output stuck at 1
    stuck1 = 1;
    q2.push_back({2'b00, 1'b1, 1'b1});
    q2.push_back({2'b01, 1'b1, 1'b1});
    q2.push_back({2'b10, 1'b1, 1'b1});
    q2.push_back({2'b11, 1'b1, 1'b0});
    start_run2(3'd0, t0);
    wait_done2("t2", t0, 28, 0, 1);
    stuck1 = 0;

    // 4: NOR expected vs NAND gate, stray start mid-run, abort in SETTLE of 10
    q2.push_back({2'b00, 1'b1, 1'b1});
    q2.push_back({2'b01, 1'b1, 1'b0});
    start_run2(3'd1, t0);
    wait_gi2(2'b01, "t4_reach_01");
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    wait_gi2(2'b10, "t4_reach_10");
    abort2 = 1;
    @(negedge clk);
    abort2 = 0;
    chk("t4_abort_state", {gi2, busy2, done2, lv2}, 0);
    chk("t4_partial_err", err2, 1);
    chk("t4_pass_kept", pass2, 0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done2 || busy2) dones++;
    end
    chk("t4_no_done", dones, 0);
    push_nand_ok();
    start_run2(3'd0, t0);
    chk("t4_err_cleared", err2, 0);
    wait_done2("t4_restart", t0, 28, 1, 0);

    // 5: async reset while in LOG
    q2.push_back({2'b00, 1'b1, 1'b1});
    start_run2(3'd0, t0);
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (lv2) hit = 1;
    end
    if (!hit) bound_fail("t5_find_log");
    #2 rst = 1;
    #1 chk("t5_async_reset", {gi2, busy2, done2, pass2, err2, lv2, lp2, lz2, le2}, 0);
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("t5_stays_idle", {busy2, gi2, lv2}, 0);

    // 6: N_IN=3, XOR expected, output stuck at 0
    q3.push_back({3'b000, 1'b0, 1'b0});
    q3.push_back({3'b001, 1'b0, 1'b1});
    q3.push_back({3'b010, 1'b0, 1'b1});
    q3.push_back({3'b011, 1'b0, 1'b0});
    q3.push_back({3'b100, 1'b0, 1'b1});
    q3.push_back({3'b101, 1'b0, 1'b0});
    q3.push_back({3'b110, 1'b0, 1'b0});
    q3.push_back({3'b111, 1'b0, 1'b1});
    @(negedge clk);
    func3 = 3'd4; start3 = 1;
    @(negedge clk);
    start3 = 0; t0 = cyc;
    hit = 0;
    for (int k = 0; k < 800 && !hit; k++) begin
      @(negedge clk);
      if (done3) hit = 1;
    end
    if (!hit) bound_fail("t6_done");
    else begin
      chk("t6_latency", cyc - t0, 56);
      chk("t6_err", err3, 4);
      chk("t6_pass", pass3, 0);
    end

    repeat (3) @(negedge clk);
    chk("q2_drained", q2.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
